// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter sharing the ULPI core register port between the init sequencer (R0)
// and host commands (R1); one transaction in flight with a per-transaction ack timeout.
module ulpi_reg_arbiter #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic [ADDR_W-1:0] R0_ADDR,
  input  logic [DATA_W-1:0] R0_WDATA,
  input  logic              R0_WRITE_REQ,
  input  logic              R0_READ_REQ,
  output logic              R0_ACK,
  output logic [DATA_W-1:0] R0_RDATA,
  output logic              R0_ERR,

  input  logic [ADDR_W-1:0] R1_ADDR,
  input  logic [DATA_W-1:0] R1_WDATA,
  input  logic              R1_WRITE_REQ,
  input  logic              R1_READ_REQ,
  output logic              R1_ACK,
  output logic [DATA_W-1:0] R1_RDATA,
  output logic              R1_ERR,

  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_DATA_WRITE,
  output logic              REG_WRITE_REQ,
  output logic              REG_READ_REQ,
  input  logic [DATA_W-1:0] REG_DATA_READ,
  input  logic              REG_WRITE_ACK,
  input  logic              REG_READ_ACK,

  output logic              BUSY,
  output logic              GRANT
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              grant_q, grant_d;
  logic              prio_q, prio_d;  // requester that wins a simultaneous request
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic pend0, pend1, pick, hit, finish, timed_out;

  assign pend0   = R0_WRITE_REQ | R0_READ_REQ;
  assign pend1   = R1_WRITE_REQ | R1_READ_REQ;
  assign hit     = is_write_q ? REG_WRITE_ACK : REG_READ_ACK;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    err_d      = err_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    pick       = 1'b0;
    finish     = 1'b0;
    timed_out  = 1'b0;

    case (state_q)
      IDLE: begin
        if (pend0 || pend1) begin
          pick       = (pend0 && pend1) ? prio_q : pend1;
          grant_d    = pick;
          prio_d     = ~pick;
          addr_d     = pick ? R1_ADDR : R0_ADDR;
          wdata_d    = pick ? R1_WDATA : R0_WDATA;
          // Write takes precedence when a requester raises both request lines.
          is_write_d = pick ? R1_WRITE_REQ : R0_WRITE_REQ;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        cnt_d = cnt_inc;
        // A matching ack on the final counted cycle still counts as a success.
        if (hit) begin
          finish = 1'b1;
        end else if (cnt_inc == CNT_MAX) begin
          finish    = 1'b1;
          timed_out = 1'b1;
        end

        if (finish) begin
          state_d = DONE;
          err_d   = timed_out;
          if (!is_write_q) begin
            if (grant_q) begin
              rdata1_d = timed_out ? '0 : REG_DATA_READ;
            end else begin
              rdata0_d = timed_out ? '0 : REG_DATA_READ;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      err_q      <= err_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Everything below is decoded from registered state, so reset clears it at once.
  assign REG_ADDR       = addr_q;
  assign REG_DATA_WRITE = wdata_q;
  assign REG_WRITE_REQ  = (state_q == ISSUE) &&  is_write_q;
  assign REG_READ_REQ   = (state_q == ISSUE) && !is_write_q;

  assign R0_ACK   = (state_q == DONE) && !grant_q;
  assign R1_ACK   = (state_q == DONE) &&  grant_q;
  assign R0_ERR   = R0_ACK && err_q;
  assign R1_ERR   = R1_ACK && err_q;
  assign R0_RDATA = rdata0_q;
  assign R1_RDATA = rdata1_q;

  assign BUSY  = (state_q != IDLE);
  assign GRANT = grant_q;

  a_one_master_req : assert property (@(posedge CLK) disable iff (!RST_N)
    !(REG_WRITE_REQ && REG_READ_REQ));
  a_one_ack : assert property (@(posedge CLK) disable iff (!RST_N)
    !(R0_ACK && R1_ACK));

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: directed scenarios followed by random traffic, every cycle checked
// against a transaction-level model of grants, master request windows and completions.
module tb_ulpi_reg_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [AW-1:0] R0_ADDR, R1_ADDR, REG_ADDR;
  logic [DW-1:0] R0_WDATA, R1_WDATA, R0_RDATA, R1_RDATA;
  logic          R0_WRITE_REQ, R0_READ_REQ, R0_ACK, R0_ERR;
  logic          R1_WRITE_REQ, R1_READ_REQ, R1_ACK, R1_ERR;
  logic [DW-1:0] REG_DATA_WRITE, REG_DATA_READ;
  logic          REG_WRITE_REQ, REG_READ_REQ, REG_WRITE_ACK, REG_READ_ACK;
  logic          BUSY, GRANT;

  always #5 CLK = ~CLK;

  ulpi_reg_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .R0_ADDR(R0_ADDR), .R0_WDATA(R0_WDATA), .R0_WRITE_REQ(R0_WRITE_REQ),
    .R0_READ_REQ(R0_READ_REQ), .R0_ACK(R0_ACK), .R0_RDATA(R0_RDATA), .R0_ERR(R0_ERR),
    .R1_ADDR(R1_ADDR), .R1_WDATA(R1_WDATA), .R1_WRITE_REQ(R1_WRITE_REQ),
    .R1_READ_REQ(R1_READ_REQ), .R1_ACK(R1_ACK), .R1_RDATA(R1_RDATA), .R1_ERR(R1_ERR),
    .REG_ADDR(REG_ADDR), .REG_DATA_WRITE(REG_DATA_WRITE), .REG_WRITE_REQ(REG_WRITE_REQ),
    .REG_READ_REQ(REG_READ_REQ), .REG_DATA_READ(REG_DATA_READ),
    .REG_WRITE_ACK(REG_WRITE_ACK), .REG_READ_ACK(REG_READ_ACK),
    .BUSY(BUSY), .GRANT(GRANT)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit            wr;
    bit            rd;
  } txn_t;

  // Requester side
  txn_t scr0[$], scr1[$];
  txn_t req_t[2];
  bit   req_on[2];
  int   gap[2];
  bit   rand_en, spur_all, spur_rand;

  // Core side script: ack delay in master-request cycles (> TO means never) and read data
  int            dly_q[$];
  logic [DW-1:0] dat_q[$];

  // Reference model
  bit            active, done_pend, exp_start, last_granted, gnt_m;
  bit            cur_owner, cur_w, cur_err;
  logic [AW-1:0] cur_a;
  logic [DW-1:0] cur_d, cur_ackdata;
  int            cur_dly, cur_len, cyc, low_cnt;
  logic [1:0]    prev_pend;
  logic [DW-1:0] rd_m[2];
  bit            glog[$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input bit wr, input bit rd);
    txn_t t;
    t.a = a; t.d = d; t.wr = wr; t.rd = rd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int k;
    k = $urandom_range(0, 3);  // 0,1 write; 2 read; 3 both lines (served as write)
    return mk(AW'($urandom), DW'($urandom), k != 2, k >= 2);
  endfunction

  function automatic bit busy_any();
    return req_on[0] || req_on[1] || active || done_pend || scr0.size() > 0 || scr1.size() > 0;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, REG_ADDR, 0);
    chk({tag, "_wdat"}, REG_DATA_WRITE, 0);
    chk({tag, "_wreq"}, REG_WRITE_REQ, 0);
    chk({tag, "_rreq"}, REG_READ_REQ, 0);
    chk({tag, "_ack0"}, R0_ACK, 0);
    chk({tag, "_ack1"}, R1_ACK, 0);
    chk({tag, "_err0"}, R0_ERR, 0);
    chk({tag, "_err1"}, R1_ERR, 0);
    chk({tag, "_rd0"}, R0_RDATA, 0);
    chk({tag, "_rd1"}, R1_RDATA, 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_grant"}, GRANT, 0);
  endtask

  task automatic drive_reqs();
    for (int n = 0; n < 2; n++) begin
      if (!req_on[n]) begin
        if (gap[n] > 0) gap[n]--;
        else if (n == 0 && scr0.size() > 0) begin req_t[0] = scr0.pop_front(); req_on[0] = 1; end
        else if (n == 1 && scr1.size() > 0) begin req_t[1] = scr1.pop_front(); req_on[1] = 1; end
        else if (rand_en && $urandom_range(0, 2) == 0) begin req_t[n] = rand_txn(); req_on[n] = 1; end
      end
    end
    R0_ADDR = req_t[0].a;  R0_WDATA = req_t[0].d;
    R0_WRITE_REQ = req_on[0] && req_t[0].wr;  R0_READ_REQ = req_on[0] && req_t[0].rd;
    R1_ADDR = req_t[1].a;  R1_WDATA = req_t[1].d;
    R1_WRITE_REQ = req_on[1] && req_t[1].wr;  R1_READ_REQ = req_on[1] && req_t[1].rd;
  endtask

  // One clock: observe at the falling edge, compare with the model, then drive the next inputs.
  task automatic cycle();
    logic          mreq, aw, ar;
    logic [DW-1:0] drd;
    bit            idle_now, w;
    int            k;
    @(negedge CLK);
    mreq = REG_WRITE_REQ | REG_READ_REQ;
    idle_now = 0; aw = 0; ar = 0; drd = DW'($urandom);
    if (done_pend) begin
      chk("done_mreq", mreq, 0);
      chk("done_busy", BUSY, 1);
      chk("ack0", R0_ACK, cur_owner == 0);
      chk("ack1", R1_ACK, cur_owner == 1);
      chk("err0", R0_ERR, cur_owner == 0 && cur_err);
      chk("err1", R1_ERR, cur_owner == 1 && cur_err);
      if (!cur_w) rd_m[cur_owner] = cur_err ? '0 : cur_ackdata;
      req_on[cur_owner] = 0;
      gap[cur_owner] = rand_en ? $urandom_range(1, 3) : 1;
      done_pend = 0;
      low_cnt++;
    end else begin
      chk("ack0_idle", R0_ACK, 0);
      chk("ack1_idle", R1_ACK, 0);
      chk("err0_idle", R0_ERR, 0);
      chk("err1_idle", R1_ERR, 0);
      if (!active) begin
        chk("start", mreq, exp_start);
        if (mreq) begin
          chk("req_gap", low_cnt >= 2, 1);
          w = (prev_pend == 2'b11) ? ~last_granted : prev_pend[1];
          cur_owner = w; last_granted = w; gnt_m = w;
          cur_a = req_t[w].a; cur_d = req_t[w].d; cur_w = req_t[w].wr;
          if (dly_q.size() > 0) cur_dly = dly_q.pop_front();
          else begin
            k = $urandom_range(0, 9);
            if (k < 8) cur_dly = k + 1;
            else cur_dly = cur_w ? $urandom_range(1, TO) : 1000;
          end
          cur_ackdata = (dat_q.size() > 0) ? dat_q.pop_front() : DW'($urandom);
          cur_len = (cur_dly <= TO) ? cur_dly : TO;
          cur_err = (cur_dly > TO);
          cyc = 0;
          active = 1;
          glog.push_back(GRANT);
        end else begin
          idle_now = 1;
          chk("idle_busy", BUSY, 0);
          low_cnt++;
        end
      end
      if (active) begin
        cyc++;
        low_cnt = 0;
        chk("issue_busy", BUSY, 1);
        chk("issue_wreq", REG_WRITE_REQ, cur_w);
        chk("issue_rreq", REG_READ_REQ, !cur_w);
        chk("issue_addr", REG_ADDR, cur_a);
        if (cur_w) chk("issue_wdata", REG_DATA_WRITE, cur_d);
        if (cyc == cur_dly) begin
          if (cur_w) aw = 1;
          else begin ar = 1; drd = cur_ackdata; end
        end else if (spur_all || (spur_rand && $urandom_range(0, 4) == 0)) begin
          if (cur_w) ar = 1; else aw = 1;
        end
        if (cyc == cur_len) begin active = 0; done_pend = 1; end
      end
    end
    chk("rdata0", R0_RDATA, rd_m[0]);
    chk("rdata1", R1_RDATA, rd_m[1]);
    chk("grant", GRANT, gnt_m);
    drive_reqs();
    exp_start = idle_now && (req_on[0] || req_on[1]);
    prev_pend = {req_on[1], req_on[0]};
    REG_WRITE_ACK = aw; REG_READ_ACK = ar; REG_DATA_READ = drd;
  endtask

  task automatic run_quiet(input int maxc);
    int c;
    c = 0;
    do begin
      cycle();
      c++;
    end while (busy_any() && c < maxc);
    chk("quiet", busy_any(), 0);
  endtask

  task automatic model_reset();
    active = 0; done_pend = 0; last_granted = 1; gnt_m = 0;
    rd_m[0] = '0; rd_m[1] = '0; low_cnt = 99;
    exp_start = req_on[0] || req_on[1];
    prev_pend = {req_on[1], req_on[0]};
  endtask

  initial begin
    int base, c;
    RST_N = 1'b0;
    req_on[0] = 0; req_on[1] = 0; gap[0] = 0; gap[1] = 0;
    req_t[0] = mk('0, '0, 0, 0); req_t[1] = mk('0, '0, 0, 0);
    rand_en = 0; spur_all = 0; spur_rand = 0;
    drive_reqs();
    REG_WRITE_ACK = 0; REG_READ_ACK = 0; REG_DATA_READ = '0;
    #1 chk_all_zero("reset");
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();

    // R0 write 0x0A/0x55 acked on the third request cycle, then an R0 read to seed R0_RDATA
    scr0.push_back(mk(6'h0A, 8'h55, 1, 0)); dly_q.push_back(3); dat_q.push_back(8'h00);
    run_quiet(40);
    scr0.push_back(mk(6'h11, 8'h00, 0, 1)); dly_q.push_back(1); dat_q.push_back(8'h3C);
    run_quiet(40);
    chk("r0_seed_rdata", R0_RDATA, 8'h3C);

    // R1 read of address 0 returns 0x24
    scr1.push_back(mk(6'h00, 8'h00, 0, 1)); dly_q.push_back(2); dat_q.push_back(8'h24);
    run_quiet(40);
    chk("r1_rdata", R1_RDATA, 8'h24);
    chk("r0_rdata_kept", R0_RDATA, 8'h3C);

    // Simultaneous requests, each side re-requesting immediately
    base = glog.size();
    for (int i = 0; i < 4; i++) begin
      scr0.push_back(rand_txn());
      scr1.push_back(rand_txn());
    end
    run_quiet(200);
    chk("rr_count", glog.size() - base, 8);
    for (int i = 0; i < 8 && base + i < glog.size(); i++) chk("rr_order", glog[base + i], i % 2);

    // R0 read never acked times out, then R1 is served normally
    scr0.push_back(mk(6'h05, 8'h00, 0, 1)); dly_q.push_back(1000); dat_q.push_back(8'h00);
    run_quiet(40);
    chk("r0_timeout_rdata", R0_RDATA, 0);
    scr1.push_back(mk(6'h06, 8'hA5, 1, 0)); dly_q.push_back(3); dat_q.push_back(8'h00);
    run_quiet(40);

    // R1 write with read acks arriving every cycle before the write ack
    spur_all = 1;
    scr1.push_back(mk(6'h2B, 8'hC3, 1, 0)); dly_q.push_back(5); dat_q.push_back(8'h00);
    run_quiet(40);
    spur_all = 0;

    // Random traffic on both requesters
    rand_en = 1; spur_rand = 1;
    repeat (2500) cycle();
    rand_en = 0; spur_rand = 0;
    run_quiet(200);

    // Asynchronous reset while an R1 transaction is in ISSUE; R1 keeps requesting
    scr1.push_back(mk(6'h3A, 8'h7E, 0, 1)); dly_q.push_back(1000); dat_q.push_back(8'h00);
    c = 0;
    do begin
      cycle();
      c++;
    end while (!(active && cur_owner == 1 && cyc == 3) && c < 50);
    chk("reach_mid_issue", c < 50, 1);
    #2 RST_N = 1'b0;
    #1 chk_all_zero("async_rst");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    dly_q.push_back(2); dat_q.push_back(8'h99);
    base = glog.size();
    run_quiet(40);
    chk("post_rst_grant_cnt", glog.size() - base, 1);
    if (glog.size() > base) chk("post_rst_grant", glog[base], 1);
    chk("post_rst_rdata", R1_RDATA, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
